// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite constants, loader states and RAM address layout
package sprite_pkg;

  localparam int SPRITE_HB = 5;
  localparam int SPRITE_VB = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } loader_state_e;

  // Sprite RAM word layout; the sprite sources compose their read address the same way.
  function automatic logic [SPRITE_VB+SPRITE_HB-1:0] sprite_addr(
    input logic [SPRITE_VB-1:0] y,
    input logic [SPRITE_HB-1:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/sprite_dest_map.sv
// rtl/sprite_dest_map.sv - maps a raster count to a sprite RAM address with optional mirroring
module sprite_dest_map
  import sprite_pkg::*;
#(
  parameter int HB = 5,
  parameter int VB = 5
) (
  input  logic [HB+VB-1:0] cnt_i,
  input  logic             flip_h_i,
  input  logic             flip_v_i,
  output logic [HB+VB-1:0] addr_o
);

  logic [HB-1:0] x, x_m;
  logic [VB-1:0] y, y_m;

  assign x   = cnt_i[HB-1:0];
  assign y   = cnt_i[HB+VB-1:HB];
  assign x_m = flip_h_i ? ~x : x;
  assign y_m = flip_v_i ? ~y : y;

  // Default geometry shares the package layout helper with the read side.
  if (HB == SPRITE_HB && VB == SPRITE_VB) begin : g_pkg_layout
    assign addr_o = sprite_addr(y_m, x_m);
  end else begin : g_generic_layout
    assign addr_o = {y_m, x_m};
  end

endmodule

// File: rtl/sprite_ram_loader.sv
// rtl/sprite_ram_loader.sv - copies one sprite bitmap from ROM into sprite RAM, optionally mirrored
module sprite_ram_loader
  import sprite_pkg::*;
#(
  parameter int CD       = 12,
  parameter int HB       = 5,
  parameter int VB       = 5,
  parameter int SRC_ADDR = 14
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [SRC_ADDR-1:0] src_base,
  input  logic                flip_h,
  input  logic                flip_v,
  output logic                busy,
  output logic                done,
  output logic [SRC_ADDR-1:0] rom_addr,
  input  logic [CD-1:0]       rom_data,
  output logic                we,
  output logic [HB+VB-1:0]    addr_w,
  output logic [CD-1:0]       pixel_out
);

  localparam int ADDR = HB + VB;

  loader_state_e       state_q;
  logic [ADDR-1:0]     cnt_q;
  logic [SRC_ADDR-1:0] base_q;
  logic                flip_h_q, flip_v_q;
  logic                busy_q, done_q, we_q;
  logic [ADDR-1:0]     addr_w_q;
  logic [SRC_ADDR-1:0] rom_addr_q;

  logic [ADDR-1:0]     addr_w_d;
  logic [SRC_ADDR-1:0] rom_addr_d;

  sprite_dest_map #(
    .HB(HB),
    .VB(VB)
  ) u_dest_map (
    .cnt_i   (cnt_q),
    .flip_h_i(flip_h_q),
    .flip_v_i(flip_v_q),
    .addr_o  (addr_w_d)
  );

  // Wraps modulo the ROM size by construction; no overflow flag is wanted.
  assign rom_addr_d = base_q + SRC_ADDR'(cnt_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      flip_h_q   <= 1'b0;
      flip_v_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_w_q   <= '0;
      rom_addr_q <= '0;
    end else begin
      we_q   <= (state_q == S_LOAD);
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_LOAD;
            cnt_q    <= '0;
            base_q   <= src_base;
            flip_h_q <= flip_h;
            flip_v_q <= flip_v;
            busy_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          cnt_q      <= cnt_q + 1'b1;
          rom_addr_q <= rom_addr_d;
          addr_w_q   <= addr_w_d;
          if (cnt_q == '1) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The last ROM word is being written this cycle.
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr  = (state_q == S_LOAD) ? rom_addr_d : rom_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign we        = we_q;
  assign addr_w    = addr_w_q;
  assign pixel_out = rom_data;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb/tb_sprite_ram_loader.sv - scoreboard bench for sprite_ram_loader
module tb_sprite_ram_loader;

  localparam int CD       = 12;
  localparam int HB       = 5;
  localparam int VB       = 5;
  localparam int SRC_ADDR = 14;
  localparam int NPIX     = 1024;

  localparam int M_NORMAL   = 0;
  localparam int M_REASSERT = 1;
  localparam int M_HOLD     = 2;
  localparam int M_RESET    = 3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start;
  logic [SRC_ADDR-1:0] src_base;
  logic                flip_h;
  logic                flip_v;
  logic                busy;
  logic                done;
  logic [SRC_ADDR-1:0] rom_addr;
  logic [CD-1:0]       rom_data;
  logic                we;
  logic [HB+VB-1:0]    addr_w;
  logic [CD-1:0]       pixel_out;

  typedef struct {
    int addr;
    int pix;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  wr_seen;
  int  done_cnt;
  int  cur_base;
  int  wr_addr[NPIX];
  int  wr_hits[NPIX];

  always #5 clk = ~clk;

  // Synchronous ROM: word[a] = a[11:0], one cycle latency.
  always @(posedge clk) rom_data <= rom_addr[CD-1:0];

  sprite_ram_loader #(
    .CD(CD),
    .HB(HB),
    .VB(VB),
    .SRC_ADDR(SRC_ADDR)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_base (src_base),
    .flip_h   (flip_h),
    .flip_v   (flip_v),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .we       (we),
    .addr_w   (addr_w),
    .pixel_out(pixel_out)
  );

  function automatic int exp_dest(input int i, input bit fh, input bit fv);
    int x, y;
    x = i % 32;
    y = i / 32;
    if (fh) x = 31 - x;
    if (fv) y = 31 - y;
    return y * 32 + x;
  endfunction

  task automatic push_expected(input int base, input bit fh, input bit fv);
    wr_t w;
    cur_base = base;
    wr_seen  = 0;
    done_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      wr_hits[i] = 0;
      wr_addr[i] = -1;
      w.addr = exp_dest(i, fh, fv);
      w.pix  = ((base + i) % 16384) % 4096;
      exp_q.push_back(w);
    end
  endtask

  // Drives start at a negedge so edge E0 samples it; returns just after E0.
  task automatic kick(input int base, input bit fh, input bit fv);
    @(negedge clk);
    src_base = SRC_ADDR'(base);
    flip_h   = fh;
    flip_v   = fv;
    start    = 1'b1;
    push_expected(base, fh, fv);
    @(posedge clk);
  endtask

  // Negedge j sits between edges E0+j-1 and E0+j.
  task automatic observe(input int j0, input int jmax, input int mode);
    bit  aborted, exp_we, exp_busy, exp_done;
    wr_t w;
    for (int j = j0; j <= jmax; j++) begin
      @(negedge clk);
      aborted  = (mode == M_RESET) && (j > 300);
      exp_we   = !aborted && j >= 2 && j <= 1025;
      exp_busy = (!aborted && j >= 1 && j <= 1025) || (mode == M_HOLD && j == 1028);
      exp_done = !aborted && j == 1026;

      checks++;
      if (we !== exp_we) begin
        errors++;
        $display("FAIL we j=%0d got=%b exp=%b", j, we, exp_we);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy j=%0d got=%b exp=%b", j, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done j=%0d got=%b exp=%b", j, done, exp_done);
      end
      if (done === 1'b1) done_cnt++;

      if (!aborted && j >= 1 && j <= 1024) begin
        checks++;
        if (int'(rom_addr) != (cur_base + j - 1) % 16384) begin
          errors++;
          $display("FAIL rom_addr j=%0d got=%h exp=%h", j, rom_addr, (cur_base + j - 1) % 16384);
        end
      end

      if (mode == M_RESET && j == 301) begin
        checks++;
        if (addr_w !== '0 || rom_addr !== '0) begin
          errors++;
          $display("FAIL reset_regs addr_w=%h rom_addr=%h exp=0", addr_w, rom_addr);
        end
      end

      if (we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_write j=%0d addr_w=%h", j, addr_w);
        end else begin
          w = exp_q.pop_front();
          if (int'(addr_w) != w.addr || int'(pixel_out) != w.pix) begin
            errors++;
            $display("FAIL write%0d addr=%h pix=%h exp_addr=%h exp_pix=%h",
                     wr_seen, addr_w, pixel_out, w.addr, w.pix);
          end
        end
        if (wr_seen < NPIX) wr_addr[wr_seen] = int'(addr_w);
        wr_hits[addr_w]++;
        wr_seen++;
      end

      case (mode)
        M_REASSERT: start = (j == 5 || j == 1026);
        M_HOLD:     start = (j < 1028);
        M_RESET: begin
          start   = 1'b0;
          reset_n = (j != 300);
        end
        default:    start = 1'b0;
      endcase
    end
  endtask

  task automatic check_full_load(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (wr_hits[i] != 1) bad++;
    checks++;
    if (wr_seen != NPIX || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_count writes=%0d left=%0d exp=1024/0", tag, wr_seen, exp_q.size());
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_coverage addrs_not_once=%0d exp=0", tag, bad);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_pulses got=%0d exp=1", tag, done_cnt);
    end
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    start    = 1'b0;
    src_base = '0;
    flip_h   = 1'b0;
    flip_v   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || addr_w !== '0 || rom_addr !== '0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b we=%b addr_w=%h rom_addr=%h exp=all0",
               busy, done, we, addr_w, rom_addr);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal;
    kick(14'h100, 1'b0, 1'b0);
    observe(1, 1030, M_NORMAL);
    check_full_load("normal");
    checks++;
    if (wr_addr[0] != 0 || wr_addr[1023] != 1023) begin
      errors++;
      $display("FAIL normal_ends first=%h last=%h exp=000/3ff", wr_addr[0], wr_addr[1023]);
    end
  endtask

  task automatic test_flip_h;
    kick(14'h040, 1'b1, 1'b0);
    observe(1, 1030, M_NORMAL);
    check_full_load("flip_h");
    checks++;
    if (wr_addr[0] != 'h01F) begin
      errors++;
      $display("FAIL flip_h_cnt0 got=%h exp=01f", wr_addr[0]);
    end
    checks++;
    if (wr_addr['h3E5] != 'h3FA) begin
      errors++;
      $display("FAIL flip_h_cnt3e5 got=%h exp=3fa", wr_addr['h3E5]);
    end
  endtask

  task automatic test_flip_hv;
    kick(14'h200, 1'b1, 1'b1);
    observe(1, 1030, M_NORMAL);
    check_full_load("flip_hv");
    checks++;
    if (wr_addr[0] != 'h3FF || wr_addr[1023] != 0) begin
      errors++;
      $display("FAIL flip_hv_ends first=%h last=%h exp=3ff/000", wr_addr[0], wr_addr[1023]);
    end
  endtask

  task automatic test_rom_wrap;
    kick(14'h3F00, 1'b0, 1'b0);
    observe(1, 1030, M_NORMAL);
    check_full_load("wrap");
  endtask

  task automatic test_start_ignored;
    kick(14'h055, 1'b0, 1'b1);
    observe(1, 1030, M_REASSERT);
    check_full_load("reassert");
  endtask

  task automatic test_back_to_back;
    kick(14'h123, 1'b1, 1'b0);
    observe(1, 1028, M_HOLD);
    check_full_load("hold_first");
    push_expected(14'h123, 1'b1, 1'b0);
    observe(2, 1030, M_NORMAL);
    check_full_load("hold_second");
  endtask

  task automatic test_reset_midload;
    kick(14'h000, 1'b0, 1'b0);
    observe(1, 1030, M_RESET);
    checks++;
    if (wr_seen != 299) begin
      errors++;
      $display("FAIL midreset_writes got=%0d exp=299", wr_seen);
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL midreset_done got=%0d exp=0", done_cnt);
    end
    exp_q.delete();
    kick(14'h2AB, 1'b1, 1'b1);
    observe(1, 1030, M_NORMAL);
    check_full_load("after_reset");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_flip_h();
    test_flip_hv();
    test_rom_wrap();
    test_start_ignored();
    test_back_to_back();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
- Write-side companion to the 32x32 sprite sources (car/mouse sprite generators).
- On a start command, copies one sprite bitmap from a synchronous bitmap ROM into a sprite RAM through that RAM's write port (we, addr_w, pixel data).
- Optionally mirrors the bitmap horizontally and/or vertically on the way in, so a single ROM image serves left/right and up/down car orientations.
- Sits between the game-control FSM and each sprite source's RAM write port.

Parameters:
- CD, 12, colour depth in bits of each pixel.
- HB, 5, log2 of sprite width (32).
- VB, 5, log2 of sprite height (32).
- SRC_ADDR, 14, ROM address width.
- ADDR (localparam), HB+VB, sprite RAM address width; default 10.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  load request, sampled only in IDLE.
- src_base  in  SRC_ADDR  ROM address of pixel (0,0), captured at start.
- flip_h  in  1  mirror in x, captured at start.
- flip_v  in  1  mirror in y, captured at start.
- busy  out  1  high from the first LOAD cycle through the DRAIN cycle.
- done  out  1  one-cycle pulse when the final write has completed.
- rom_addr  out  SRC_ADDR  ROM read address.
- rom_data  in  CD  ROM read data, valid exactly one cycle after rom_addr.
- we  out  1  sprite RAM write enable.
- addr_w  out  ADDR  sprite RAM write address, layout {y[VB-1:0], x[HB-1:0]}.
- pixel_out  out  CD  sprite RAM write data.

Behaviour:
- Reset values (reset_n low at a clock edge): state IDLE, cnt 0, busy 0, done 0, we 0, addr_w 0, rom_addr 0. Reset mid-load aborts immediately; no further writes occur.
- States and transitions:
  - IDLE: start=1 goes to LOAD, captures src_base/flip_h/flip_v, sets cnt=0.
  - LOAD: cnt increments each cycle; at cnt = 2^ADDR-1 goes to DRAIN.
  - DRAIN: one cycle, then DONE.
  - DONE: one cycle with done=1, then IDLE.
- rom_addr = src_base_reg + cnt (combinational in LOAD), truncated modulo 2^SRC_ADDR; wrap past the ROM top is allowed and not flagged. Outside LOAD, rom_addr holds its last value.
- Write stage registers:
  - we_reg is LOAD delayed by one cycle.
  - addr_w_reg = dest(cnt) registered, where dest(cnt):
    - x = cnt[HB-1:0], y = cnt[ADDR-1:HB].
    - x' = flip_h ? ~x : x; y' = flip_v ? ~y : y.
    - dest = {y', x'}.
  - pixel_out = rom_data (combinational pass-through), so the data aligns with we/addr_w.
- Timing, with start sampled at edge E0:
  - LOAD cycles are E0+1 .. E0+1024.
  - Writes occur at E0+2 .. E0+1025; the E0+1025 write happens in DRAIN.
  - done is high for exactly the cycle E0+1026.
  - Total 1026 cycles start-to-done; exactly 1024 writes, each RAM address written once.
- start while busy or in DONE is ignored, not queued. start held high continuously begins a new load in the first IDLE cycle after DONE.
- Changes to src_base/flip inputs after capture have no effect until the next start.
- we is never high outside the window above.

Decomposition:
- Shared package sprite_pkg holds:
  - the loader state enum (IDLE, LOAD, DRAIN, DONE);
  - the SPRITE_HB/SPRITE_VB constants (5/5);
  - the address-layout function {y,x}, shared with the sprite sources' read-address composition.
- One natural sub-module: sprite_dest_map (combinational cnt + flips -> addr_w). Everything else lives in the top.

Test Plan:
- Normal load: ROM model word[a] = a[11:0]; src_base=0x100, no flips; pulse start.
  - Expect 1024 writes with addr_w[i]=i and pixel=0x100+i.
  - Expect busy for 1025 cycles and done exactly 1026 cycles after the start edge.
- flip_h=1 only: write for cnt=0x000 goes to addr 0x01F; cnt=0x3E5 goes to addr 0x3FA.
- flip_h=1, flip_v=1: cnt=0 goes to 0x3FF and cnt=0x3FF goes to 0x000; each address is written exactly once (scoreboard covers all 1024 addresses).
- ROM wrap: src_base=0x3F00, SRC_ADDR=14. rom_addr goes 0x3FFF then 0x0000 at cnt=0x100; data follows the ROM model with no stall.
- start re-asserted at cycles E0+5 and E0+1026: both ignored; single done pulse. start held high: second load begins at E0+1027 (next LOAD at E0+1028).
- reset_n low at E0+300 for one cycle: we=0 from the next edge, no further writes, busy=0, done never pulses, returns to IDLE. A new start then performs a full, correct load.
